// File: rtl/page_table_walker.sv
// Radix-tree page-table walker: one PTE read per level, permission check, leaf/fault result.
// Define PTW_SUPERPAGE_EN to accept aligned leaves above level 0.
module page_table_walker #(
  parameter int Levels        = 2,
  parameter int VpnSliceWidth = 10,
  parameter int PteSizeLog2   = 2,
  parameter int PpnWidth      = 22,
  localparam int PteWidth     = 8 << PteSizeLog2,
  localparam int PaddrWidth   = PpnWidth + 12,
  localparam int VpnWidth     = Levels * VpnSliceWidth,
  localparam int LvlWidth     = $clog2(Levels)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VpnWidth-1:0]   req_vpn,
  input  logic                  req_is_write,
  input  logic                  req_is_exec,
  input  logic [PpnWidth-1:0]   satp_ppn,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PaddrWidth-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [PteWidth-1:0]   mem_resp_data,
  output logic                  resp_valid,
  output logic                  resp_fault,
  output logic [PteWidth-1:0]   resp_pte,
  output logic [LvlWidth-1:0]   resp_level
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [LvlWidth-1:0]   level_q;
  logic [PpnWidth-1:0]   table_ppn_q;
  logic [VpnWidth-1:0]   vpn_q;
  logic                  is_write_q;
  logic                  is_exec_q;
  logic [PteWidth-1:0]   pte_q;
  logic                  fault_q;

  logic                  accept;
  logic                  resp_take;
  logic                  fault_d;
  logic                  descend;
  logic [PpnWidth-1:0]   pte_ppn;
  logic [VpnSliceWidth-1:0] vpn_slice;
  logic pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;

  assign accept    = (state_q == IDLE) && req_valid;
  assign resp_take = (state_q == WAIT) && mem_resp_valid;

  assign pte_v   = mem_resp_data[0];
  assign pte_r   = mem_resp_data[1];
  assign pte_w   = mem_resp_data[2];
  assign pte_x   = mem_resp_data[3];
  assign pte_a   = mem_resp_data[6];
  assign pte_d   = mem_resp_data[7];
  assign pte_ppn = mem_resp_data[10 +: PpnWidth];

  assign vpn_slice =
    vpn_q[int'(level_q)*VpnSliceWidth +: VpnSliceWidth];

`ifdef PTW_SUPERPAGE_EN
  logic misaligned;

  // Superpage leaves must have every PPN slice below their level clear.
  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < Levels - 1; i++) begin
      if (i < int'(level_q) &&
          pte_ppn[i*VpnSliceWidth +: VpnSliceWidth] != '0)
        misaligned = 1'b1;
    end
  end
`endif

  always_comb begin
    fault_d = 1'b0;
    descend = 1'b0;
    if (!pte_v || (!pte_r && pte_w)) begin
      fault_d = 1'b1;
    end else if (pte_r || pte_x) begin
`ifdef PTW_SUPERPAGE_EN
      if (misaligned) fault_d = 1'b1;
`else
      if (level_q != '0) fault_d = 1'b1;
`endif
      if (!pte_a) fault_d = 1'b1;
      if (is_write_q) begin
        if (!pte_w || !pte_d) fault_d = 1'b1;
      end else if (is_exec_q) begin
        if (!pte_x) fault_d = 1'b1;
      end else if (!pte_r) begin
        fault_d = 1'b1;
      end
    end else if (level_q == '0) begin
      fault_d = 1'b1;
    end else begin
      descend = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_valid) state_d = ISSUE;
      ISSUE: if (mem_req_ready) state_d = WAIT;
      WAIT:  if (mem_resp_valid) state_d = descend ? ISSUE : DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= '0;
      table_ppn_q <= '0;
      vpn_q       <= '0;
      is_write_q  <= 1'b0;
      is_exec_q   <= 1'b0;
      pte_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (accept) begin
        level_q     <= LvlWidth'(Levels - 1);
        table_ppn_q <= satp_ppn;
        vpn_q       <= req_vpn;
        is_write_q  <= req_is_write;
        is_exec_q   <= req_is_exec & ~req_is_write;
        fault_q     <= 1'b0;
      end
      if (resp_take) begin
        pte_q   <= mem_resp_data;
        fault_q <= fault_d;
        if (descend) begin
          table_ppn_q <= pte_ppn;
          level_q     <= level_q - LvlWidth'(1);
        end
      end
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = (state_q == ISSUE) ?
    {table_ppn_q, vpn_slice, {PteSizeLog2{1'b0}}} : '0;
  assign resp_valid    = (state_q == DONE);
  assign resp_fault    = fault_q;
  assign resp_pte      = pte_q;
  assign resp_level    = level_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Randomised bench for page_table_walker against a flat-arithmetic Sv32 walk model.
// Honours PTW_SUPERPAGE_EN the same way the design does.
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic        req_is_write;
  logic        req_is_exec;
  logic [21:0] satp_ppn;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [33:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] resp_pte;
  logic [0:0]  resp_level;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [longint];
  longint      exp_addr [4];

  always #5 clk = ~clk;

  page_table_walker dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_vpn       (req_vpn),
    .req_is_write  (req_is_write),
    .req_is_exec   (req_is_exec),
    .satp_ppn      (satp_ppn),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .resp_valid    (resp_valid),
    .resp_fault    (resp_fault),
    .resp_pte      (resp_pte),
    .resp_level    (resp_level)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input longint a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] mk_pte(input longint ppn,
                                         input logic [7:0] fl);
    logic [21:0] p;
    p = 22'(ppn);
    return {p, 2'b00, fl};
  endfunction

  // Reference walk: plain Sv32 arithmetic, one table read per level.
  function automatic void ref_walk(input longint satp, input longint vpn,
      input bit wr, input bit ex, output bit flt,
      output logic [31:0] pte, output int lvl, output int nacc);
    longint ppn, a;
    bit ok;
    ppn = satp; flt = 1'b1; pte = '0; nacc = 0;
    for (lvl = 1; lvl >= 0; lvl--) begin
      a = ppn * 4096 + ((vpn >> (10 * lvl)) % 1024) * 4;
      exp_addr[nacc] = a;
      nacc++;
      pte = rd(a);
      if (!pte[0] || (!pte[1] && pte[2])) return;
      if (pte[1] || pte[3]) begin
        ok = pte[6] && (wr ? (pte[2] && pte[7]) : ex ? pte[3] : pte[1]);
`ifdef PTW_SUPERPAGE_EN
        if (lvl > 0 && ((pte >> 10) % 1024) != 0) ok = 1'b0;
`else
        if (lvl > 0) ok = 1'b0;
`endif
        flt = !ok;
        return;
      end
      if (lvl == 0) return;
      ppn = longint'(pte >> 10) % (1 << 22);
    end
  endfunction

  task automatic run_walk(input longint satp, input longint vpn,
      input bit wr, input bit ex, input int rdy_dly, input int rsp_dly,
      input int exp_t);
    bit eflt, done, waiting, held;
    logic [31:0] epte;
    int elvl, enacc, t, nreq, rdy_cnt, rsp_cnt;
    longint haddr, last_addr;
    ref_walk(satp, vpn, wr, ex, eflt, epte, elvl, enacc);
    @(negedge clk);
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_vpn = 20'(vpn); satp_ppn = 22'(satp);
    req_is_write = wr; req_is_exec = ex;
    t = 0; nreq = 0; done = 0; waiting = 0; held = 0;
    haddr = 0; last_addr = 0; rsp_cnt = 0;
    rdy_cnt = rdy_dly < 0 ? $urandom_range(0, 3) : rdy_dly;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
      if (t == 1) req_valid = 1'b0;
      mem_resp_valid = 1'b0;
      if (resp_valid) begin
        done = 1;
        check("fault", resp_fault, eflt);
        check("pte", resp_pte, epte);
        check("level", resp_level, elvl);
        check("nreq", nreq, enacc);
        check("busy_ready", req_ready, 0);
        if (exp_t >= 0) check("latency", t, exp_t);
      end else begin
        if (waiting) begin
          if (rsp_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = rd(haddr);
            waiting = 0;
          end else rsp_cnt--;
        end
        if (held) begin
          check("valid_held", mem_req_valid, 1);
          check("addr_stable", mem_req_addr, last_addr);
        end
        if (mem_req_valid) begin
          if (rdy_cnt == 0) begin
            mem_req_ready = 1'b1;
            haddr = longint'(mem_req_addr);
            if (nreq < enacc) check("addr", mem_req_addr, exp_addr[nreq]);
            else check("extra_req", nreq, enacc);
            nreq++;
            waiting = 1; held = 0;
            rsp_cnt = rsp_dly < 0 ? $urandom_range(0, 3) : rsp_dly;
            rdy_cnt = rdy_dly < 0 ? $urandom_range(0, 3) : rdy_dly;
          end else begin
            mem_req_ready = 1'b0;
            rdy_cnt--;
            held = 1;
            last_addr = longint'(mem_req_addr);
          end
        end else begin
          mem_req_ready = 1'b0;
          held = 0;
        end
      end
    end
    check("walk_done", done, 1);
    @(negedge clk);
    check("pulse_once", resp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  function automatic logic [7:0] rnd_flags(input bit leaf);
    logic [7:0] fl;
    fl = 8'($urandom);
    if ($urandom_range(0, 7) != 0) fl[0] = 1'b1;
    if ($urandom_range(0, 3) != 0) fl[6] = 1'b1;
    if (leaf && fl[3:1] == 3'b000) fl[1] = 1'b1;
    return fl;
  endfunction

  initial begin
    longint satp, vpn, ra, ppn;
    logic [31:0] root;
    bit wr, ex;
    rst = 1'b1; req_valid = 0; req_vpn = 0; req_is_write = 0;
    req_is_exec = 0; satp_ppn = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_fault", resp_fault, 0);
    check("rst_pte", resp_pte, 0);
    check("rst_level", resp_level, 0);
    check("rst_addr", mem_req_addr, 0);
    rst = 1'b0;

    mem.delete();
    mem[64'h80120] = 32'h24001;
    mem[64'h90D14] = 32'h28043;
    check("plan_read_pte", rd(64'h90D14), 32'h28043);
    run_walk(64'h80, 64'h12345, 0, 0, 0, 0, 5);

    mem[64'h90D14] = 32'h28047;
    run_walk(64'h80, 64'h12345, 1, 0, 0, 0, 5);

    mem.delete();
    run_walk(64'h80, 64'h12345, 0, 0, 0, 0, 3);

    mem[64'h80120] = 32'h100043;
    run_walk(64'h80, 64'h12345, 0, 0, 0, 0, 3);
    mem[64'h80120] = 32'h100443;
    run_walk(64'h80, 64'h12345, 0, 0, 0, 0, 3);

    mem[64'h80120] = 32'h24001;
    mem[64'h90D14] = 32'h28043;
    run_walk(64'h80, 64'h12345, 0, 0, 5, 2, -1);

    // Abort a walk while it waits for its first PTE.
    @(negedge clk);
    req_valid = 1'b1; req_vpn = 20'h12345; satp_ppn = 22'h80;
    req_is_write = 0; req_is_exec = 0;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", req_ready, 1);
    check("abort_mem_valid", mem_req_valid, 0);
    check("abort_resp", resp_valid, 0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h24001;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stale_resp", resp_valid, 0);
      check("stale_mem_valid", mem_req_valid, 0);
      check("stale_ready", req_ready, 1);
      @(negedge clk);
    end
    run_walk(64'h80, 64'h12345, 0, 1, 0, 0, 5);

    for (int n = 0; n < 60; n++) begin
      mem.delete();
      satp = longint'($urandom_range(0, 32'h3FFFFF));
      vpn  = longint'($urandom_range(0, 32'hFFFFF));
      wr = 1'($urandom); ex = 1'($urandom);
      ra = satp * 4096 + (vpn / 1024) * 4;
      ppn = longint'($urandom_range(0, 32'h3FFFFF));
      if ($urandom_range(0, 1) != 0) ppn = ppn - (ppn % 1024);
      case ($urandom_range(0, 3))
        0, 1: root = mk_pte(ppn, 8'h01 | (rnd_flags(0) & 8'hF0));
        2:    root = mk_pte(ppn, rnd_flags(1));
        default: root = $urandom;
      endcase
      mem[ra] = root;
      if (root[3:0] == 4'b0001)
        mem[ppn * 4096 + (vpn % 1024) * 4] =
          mk_pte(longint'($urandom_range(0, 32'h3FFFFF)), rnd_flags(1));
      run_walk(satp, vpn, wr, ex, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/page_table_walker.md
# page_table_walker

Hardware page-table walker for the MMU, sitting between the TLB miss path and the data-side memory port. It generalises the Sv32 page-table definitions to any radix-tree scheme with a parametrised level count, VPN slice width, PTE size and PPN width, so Sv32 and Sv39 are both covered. It walks the tree one level per memory access, checks permissions, and returns the leaf PTE or a page fault. It does not update A or D bits; a clear A, or a clear D on a store, is a fault.

## Interface
- `Levels`, 2: number of tree levels (Sv32=2, Sv39=3).
- `VpnSliceWidth`, 10: VPN bits per level (Sv32=10, Sv39=9).
- `PteSizeLog2`, 2: log2 of PTE bytes (Sv32=2, Sv39=3).
- `PpnWidth`, 22: PPN width (Sv32=22, Sv39=44).
- Derived: PteWidth = 8<<PteSizeLog2; PaddrWidth = PpnWidth+12; VpnWidth = Levels*VpnSliceWidth.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Reset is synchronous and active-high.
- `req_valid`  in  1  walk request.
- `req_ready`  out  1  walker idle; the request is accepted when both `req_valid` and `req_ready` are high.
- `req_vpn`  in  VpnWidth  virtual page number.
- `req_is_write`  in  1  store access.
- `req_is_exec`  in  1  instruction fetch. Write has priority if both `req_is_write` and `req_is_exec` are set.
- `satp_ppn`  in  PpnWidth  root table PPN, sampled at accept.
- `mem_req_valid`  out  1  PTE read request.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  PaddrWidth  PTE physical address.
- `mem_resp_valid`  in  1  PTE data valid.
- `mem_resp_data`  in  PteWidth  PTE.
- `resp_valid`  out  1  single-cycle result pulse.
- `resp_fault`  out  1  page fault.
- `resp_pte`  out  PteWidth  final PTE read (the faulting PTE on a fault).
- `resp_level`  out  $clog2(Levels)  level at which the walk ended.

## Operation
- PTE layout:
  - Flags: V[0], R[1], W[2], X[3], U[4], G[5], A[6], D[7].
  - PPN: bits [10 +: PpnWidth].
  - PPN slice i is VpnSliceWidth wide at offset i*VpnSliceWidth, except the top slice, which takes the remaining bits.
  - Bits above the PPN are ignored.
- Registered state: current level, current table PPN, latched VPN, access type, latched PTE.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: `req_ready`=1. On accept, latch inputs, set level=Levels-1 and table PPN=`satp_ppn`, then go to ISSUE.
  - ISSUE: `mem_req_valid`=1 and `mem_req_addr` = {tablePPN, vpn[level], PteSizeLog2 zeros}. Address and valid stay stable until `mem_req_ready`, then go to WAIT.
  - WAIT: on `mem_resp_valid`, latch the PTE and evaluate it:
    1. V=0, or R=0 with W=1: fault.
    2. R=1 or X=1 (leaf):
       - level>0 and any PPN slice below `level` nonzero (misaligned superpage): fault.
       - A=0: fault.
       - Write access with W=0 or D=0: fault.
       - Exec access with X=0: fault.
       - Read access with R=0: fault.
       - Otherwise success.
    3. Non-leaf at level 0: fault.
    4. Non-leaf at level>0: table PPN = PTE PPN, level decrements, go to ISSUE.
    - Any terminal outcome (fault or success) goes to DONE.
  - DONE: `resp_valid`=1 for exactly one cycle with the registered fault, PTE and level, then go to IDLE.
- `mem_resp_valid` outside WAIT is ignored.
- `req_valid` outside IDLE is not accepted.

## Timing
- Reset values: `req_ready`=1 (state IDLE); `mem_req_valid`=0; `resp_valid`=0; `resp_fault`=0; `resp_pte`=0; `resp_level`=0; `mem_req_addr`=0.
- Cycle-by-cycle:
  - Accept in cycle T.
  - `mem_req_valid` high from T+1.
  - WAIT entered the cycle after the `mem_req_ready` handshake.
  - The response is evaluated in the cycle it arrives; the next state is ISSUE or DONE in the following cycle.
- Zero-wait two-level walk: accept T0, issue T1, response T2, issue T3, response T4, `resp_valid` T5.
- Best case per level is 2 cycles. A fault at the root costs T0 to T3.
- `rst` asserted in any state forces IDLE on the next edge and drops `mem_req_valid`. A pending memory response arriving afterwards is ignored. No `resp_valid` is emitted for the aborted walk.
- `req_ready` is low from the cycle after accept until the cycle after DONE.

## Configuration
- `PTW_SUPERPAGE_EN` defined: leaves at level>0 are legal megapages/gigapages, subject to the alignment check.
- Undefined: any leaf at level>0 is a fault, with `resp_level` set to that level, and the alignment logic is not compiled.

## Test plan
All scenarios use default parameters, `satp_ppn`=0x00080 and `req_vpn`=0x12345 unless stated otherwise.
- Read walk (`req_is_write`=0, `req_is_exec`=0): expect the address 0x80120; return 0x24001. Expect the address 0x90D14; return 0x28043. Expect `resp_valid` at T5 with fault=0, pte=0x28043, level=0.
- Store to a leaf with D=0: same walk with `req_is_write`=1; level-0 PTE 0x28047 -> fault=1, pte=0x28047, level=0.
- Invalid root: level-1 PTE 0x00000000 -> exactly one memory request, fault=1, level=1, `resp_valid` at T3.
- Superpage, macro defined: level-1 PTE 0x100043 -> fault=0, level=1. Level-1 PTE 0x100443 (misaligned) -> fault=1.
- Superpage, macro undefined: level-1 PTE 0x100043 -> fault=1, level=1.
- Backpressure and reset: hold `mem_req_ready`=0 for 5 cycles -> address stable and `mem_req_valid` held. Assert `rst` in WAIT -> IDLE, `req_ready`=1, no `resp_valid`. A later `mem_resp_valid` is ignored.
